// File: rtl/mul_arbiter.sv
// Arbiter sharing one external MUL_LAT-deep 8x8 multiplier among NREQ requesters, with in-order tagged returns.
// Define MUL_ARB_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 7
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NREQ-1:0]                   req_valid,
    input  logic [8*NREQ-1:0]                 req_a,
    input  logic [8*NREQ-1:0]                 req_b,
    output logic [NREQ-1:0]                   req_ready,
    output logic [7:0]                        mul_a,
    output logic [7:0]                        mul_b,
    input  logic [15:0]                       mul_p,
    output logic [NREQ-1:0]                   res_valid,
    output logic [15:0]                       res_data,
    output logic [$clog2(MUL_LAT+2)-1:0]      inflight,
    output logic                              idle
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MUL_LAT + 2);
    localparam logic [CW-1:0] MAX_INFL = CW'(MUL_LAT + 1);

    logic                        grant_any;
    logic [IW-1:0]               grant_idx;
    logic                        xfer;
    logic                        retire;
    logic [MUL_LAT:0]            tag_v;
    logic [MUL_LAT:0][IW-1:0]    tag_id;

`ifdef MUL_ARB_RR_EN
    logic [IW-1:0] ptr;

    // Search starts at the pointer and ascends with wrap; first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
        end
    end
`else
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = IW'(k);
            end
        end
    end
`endif

    // rst_n gates the grant so req_ready is zero during reset and live on the first cycle after it.
    assign xfer      = grant_any & rst_n;
    assign req_ready = xfer ? (NREQ'(1) << grant_idx) : '0;
    assign retire    = tag_v[MUL_LAT];
    assign idle      = (inflight == '0) && ((req_valid == '0) || !rst_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (xfer) begin
            mul_a <= req_a[int'(grant_idx)*8 +: 8];
            mul_b <= req_b[int'(grant_idx)*8 +: 8];
        end
    end

    // Tag stage k lines up with the multiplier's k-th pipeline cycle; the last stage meets a valid mul_p.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v  <= {tag_v[MUL_LAT-1:0], xfer};
            tag_id <= {tag_id[MUL_LAT-1:0], grant_idx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= '0;
            res_data  <= '0;
        end else begin
            res_valid <= retire ? (NREQ'(1) << tag_id[MUL_LAT]) : '0;
            if (retire) begin
                res_data <= mul_p;
            end
        end
    end

    // An op counts from its transfer edge until the edge that raises its res_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            case ({xfer, retire})
                2'b10: if (inflight != MAX_INFL) inflight <= inflight + CW'(1);
                2'b01: if (inflight != '0) inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with an ideal MUL_LAT-deep multiplier model.
// Follows MUL_ARB_RR_EN the same way the design does.
module tb_mul_arbiter;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 7;
    localparam int LAT     = MUL_LAT + 2;
    localparam int IW      = $clog2(NREQ);
    localparam int EW      = 16 + IW + 16;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [NREQ-1:0]              req_valid = '0;
    logic [8*NREQ-1:0]            req_a = '0;
    logic [8*NREQ-1:0]            req_b = '0;
    logic [NREQ-1:0]              req_ready;
    logic [7:0]                   mul_a;
    logic [7:0]                   mul_b;
    logic [15:0]                  mul_p;
    logic [NREQ-1:0]              res_valid;
    logic [15:0]                  res_data;
    logic [$clog2(MUL_LAT+2)-1:0] inflight;
    logic                         idle;

    mul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .res_valid(res_valid), .res_data(res_data), .inflight(inflight), .idle(idle)
    );

    // clock / reset
    always #5 clk = ~clk;

    // ideal multiplier, deliberately never reset
    logic [15:0] mpipe [MUL_LAT];
    initial for (int i = 0; i < MUL_LAT; i++) mpipe[i] = '0;
    always @(posedge clk) begin
        mpipe[0] <= 16'(mul_a) * 16'(mul_b);
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_p = mpipe[MUL_LAT-1];

    // scoreboard state: {due_cycle, owner, product}
    logic [EW-1:0] exp_q [$];
    bit            hist [$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            rr_next = 0;
    logic [7:0]    exp_ma = '0;
    logic [7:0]    exp_mb = '0;
    logic [15:0]   last_res = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // one clock cycle: check outputs at negedge, update the model, advance past posedge
    task automatic step();
        int              exp_idx;
        int              infl;
        logic [NREQ-1:0] exp_rdy;
        logic [15:0]     prod;
        @(negedge clk);
        check("mul_a", 32'(mul_a), 32'(exp_ma));
        check("mul_b", 32'(mul_b), 32'(exp_mb));
        exp_idx = -1;
        exp_rdy = '0;
        if (rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
`ifdef MUL_ARB_RR_EN
                i = (rr_next + k) % NREQ;
`else
                i = k;
`endif
                if (exp_idx < 0 && req_valid[i]) exp_idx = i;
            end
        end
        if (exp_idx >= 0) exp_rdy[exp_idx] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        infl = 0;
        for (int k = 0; k < hist.size() && k < LAT - 1; k++) infl += int'(hist[k]);
        check("inflight", 32'(inflight), 32'(infl));
        check("idle", 32'(idle), 32'(!rst_n || (infl == 0 && req_valid == '0)));
        if (exp_idx >= 0) begin
            exp_ma  = req_a[8*exp_idx +: 8];
            exp_mb  = req_b[8*exp_idx +: 8];
            prod    = 16'(exp_ma) * 16'(exp_mb);
            exp_q.push_back({16'(cyc + LAT), IW'(exp_idx), prod});
            rr_next = (exp_idx + 1) % NREQ;
        end
        hist.push_front(exp_idx >= 0);
        if (hist.size() > 16) void'(hist.pop_back());
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic [NREQ-1:0] v, input logic [8*NREQ-1:0] a, input logic [8*NREQ-1:0] b);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        step();
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[8*i +: 8] = 8'($urandom_range(0, 255));
            req_b[8*i +: 8] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        req_valid = '1;
        exp_q.delete();
        hist.delete();
        rr_next = 0;
        exp_ma  = '0;
        exp_mb  = '0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        for (int n = 0; n < 2 * LAT && exp_q.size() > 0; n++) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a result
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [NREQ-1:0] own;
        if (!rst_n) begin
            last_res = '0;
            check("rst_res_valid", 32'(res_valid), 32'd0);
            check("rst_res_data", 32'(res_data), 32'd0);
        end else if (res_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_res", 32'(res_valid), 32'd0);
            end else begin
                e   = exp_q.pop_front();
                own = NREQ'(1) << e[16 +: IW];
                check("res_valid", 32'(res_valid), 32'(own));
                check("res_data", 32'(res_data), 32'(e[15:0]));
                check("res_cycle", 32'(cyc), 32'(e[EW-1 -: 16]));
                last_res = e[15:0];
            end
        end else begin
            check("res_hold", 32'(res_data), 32'(last_res));
            if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 16]) <= cyc) begin
                e   = exp_q.pop_front();
                own = NREQ'(1) << e[16 +: IW];
                check("res_missing", 32'(res_valid), 32'(own));
            end
        end
    end

    initial begin
        logic [8*NREQ-1:0] a_ff;
        logic [8*NREQ-1:0] b_ff;
        do_reset(2);

        // single requester 1, 0xFF * 0xFF
        a_ff = '0;
        b_ff = '0;
        a_ff[15:8] = 8'hFF;
        b_ff[15:8] = 8'hFF;
        drive(4'b0010, a_ff, b_ff);
        req_valid = '0;
        repeat (LAT + 3) step();

        // all requesters valid continuously
        for (int n = 0; n < 24; n++) begin
            rand_ops();
            req_valid = '1;
            step();
        end
        drain();

        // requester 3 alone, then 0 and 3 together
        rand_ops();
        drive(4'b1000, req_a, req_b);
        rand_ops();
        drive(4'b1001, req_a, req_b);
        drain();

        // random traffic
        for (int n = 0; n < 300; n++) begin
            rand_ops();
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if ($urandom_range(0, 3) == 0) req_valid = '0;
            step();
        end
        drain();

        // reset while three ops are in flight
        for (int n = 0; n < 3; n++) begin
            rand_ops();
            req_valid = NREQ'(1) << $urandom_range(0, NREQ - 1);
            step();
        end
        req_valid = '0;
        step();
        do_reset(2);
        rand_ops();
        drive(4'b0100, req_a, req_b);
        drain();
        req_valid = '0;
        repeat (LAT + 3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 NREQ, 4, number of requesters sharing the multiplier (legal 2..8).
REQ-002 MUL_LAT, 7, fixed pipeline depth in cycles of the external 8x8 Vedic multiplier, from operands registered at its input to product valid at its output.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  NREQ  requester i has an operand pair pending.
REQ-006 req_a  input  8*NREQ  packed operand A, requester i at bits [8i+7:8i].
REQ-007 req_b  input  8*NREQ  packed operand B, same packing.
REQ-008 req_ready  output  NREQ  grant; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 mul_a  output  8  registered operand A to the multiplier.
REQ-010 mul_b  output  8  registered operand B to the multiplier.
REQ-011 mul_p  input  16  multiplier product, valid MUL_LAT cycles after the mul_a/mul_b update.
REQ-012 res_valid  output  NREQ  one-cycle, one-hot pulse marking the owner of res_data.
REQ-013 res_data  output  16  registered product.
REQ-014 inflight  output  $clog2(MUL_LAT+2)  number of issued operations whose results are not yet returned.
REQ-015 idle  output  1  high when inflight is 0 and req_valid is all zero.

Function
REQ-016 req_ready is combinational from req_valid and the arbitration state; it is zero or one-hot; req_ready[i] is never high while req_valid[i] is low.
REQ-017 At most one transfer per cycle; sustained throughput is one operation per cycle; no stall is caused by results in flight.
REQ-018 On a transfer from requester i, mul_a/mul_b load that requester's operands at the same edge; with no transfer, mul_a/mul_b hold their values.
REQ-019 A tag pipeline of valid bit plus requester index, MUL_LAT+1 stages deep, tracks every issue; a non-issue cycle inserts an invalid tag.
REQ-020 When the tag reaches the final stage, res_data is registered from mul_p and res_valid[tag] is pulsed for exactly one cycle; total latency is MUL_LAT+2 cycles from the transfer edge to the res_valid cycle.
REQ-021 res_data holds its last value when res_valid is zero; results are returned in issue order, with no backpressure.
REQ-022 Round-robin pointer: after a grant to i, pointer = (i+1) mod NREQ, so NREQ-1 wraps to 0; with no grant, the pointer holds; the search starts at the pointer, ascending with wrap.
REQ-023 Fairness: a requester holding req_valid high is granted within NREQ cycles.
REQ-024 inflight increments on a transfer and decrements on a res_valid pulse; when both happen in the same cycle it is unchanged; its maximum is MUL_LAT+1 and it never wraps.
REQ-025 The product is unsigned 8x8->16; no truncation or sign extension.

Reset
REQ-026 While rst_n is low: req_ready, res_valid, mul_a, mul_b, res_data and inflight are 0; idle is 1; the pointer is 0; all tags are invalid.
REQ-027 Reset mid-operation discards all in-flight results; no res_valid is produced for operations issued before reset, even if mul_p keeps changing.
REQ-028 Grants resume in the first cycle after rst_n deasserts.

Configuration
REQ-029 MUL_ARB_RR_EN defined: round-robin arbitration per REQ-022/023.
REQ-030 MUL_ARB_RR_EN undefined: fixed priority, with the lowest requesting index winning; the pointer logic is absent; REQ-023 is waived; all other requirements hold.

Verification (MUL_LAT=7, NREQ=4, ideal multiplier model)
REQ-031 Single requester 1 with a=8'hFF, b=8'hFF for one cycle -> res_valid=4'b0010 exactly 9 cycles later, res_data=16'hFE01, inflight 1 then 0.
REQ-032 All four valid continuously, RR build -> grant sequence 0,1,2,3,0,...; every cycle issues; inflight saturates at 8; results return in order with correct owners.
REQ-033 Same stimulus, non-RR build -> requester 0 granted every cycle; requesters 1-3 never granted.
REQ-034 Requester 3 granted, then requesters 0 and 3 both valid -> requester 0 granted next (wrap); a transfer and a retire in the same cycle leave inflight unchanged.
REQ-035 Issue 3 ops, assert rst_n low for 2 cycles at cycle 4 -> no res_valid for those ops; a new op issued after reset returns its correct product after 9 cycles.
